// File: rtl/cache_port_arbiter_if.sv
// Purpose: bundles the two requester ports and the cache port of cache_port_arbiter.
// Ports: I_* fetch requester, D_* load/store requester, C_*/Cache_* cache side, GNT/ERR status.
// Modports: master = arbiter view (drives cache and responses), slave = environment view.
interface cache_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          I_REQ;
    logic [AW-1:0] I_ADDR;
    logic [DW-1:0] I_RDATA;
    logic          I_DONE;

    logic          D_REQ;
    logic          D_WE;
    logic [3:0]    D_BE;
    logic [AW-1:0] D_ADDR;
    logic [DW-1:0] D_WDATA;
    logic [DW-1:0] D_RDATA;
    logic          D_DONE;

    logic          C_REQ;
    logic          C_WE;
    logic [3:0]    C_BE;
    logic [AW-1:0] C_ADDR;
    logic [DW-1:0] C_WDATA;
    logic [DW-1:0] C_RDATA;
    logic          Cache_RDY;
    logic          Cache_VALID;

    logic [1:0]    GNT;
    logic          ERR;

    modport master (
        input  I_REQ, I_ADDR,
        output I_RDATA, I_DONE,
        input  D_REQ, D_WE, D_BE, D_ADDR, D_WDATA,
        output D_RDATA, D_DONE,
        output C_REQ, C_WE, C_BE, C_ADDR, C_WDATA,
        input  C_RDATA, Cache_RDY, Cache_VALID,
        output GNT, ERR
    );

    modport slave (
        output I_REQ, I_ADDR,
        input  I_RDATA, I_DONE,
        output D_REQ, D_WE, D_BE, D_ADDR, D_WDATA,
        input  D_RDATA, D_DONE,
        input  C_REQ, C_WE, C_BE, C_ADDR, C_WDATA,
        output C_RDATA, Cache_RDY, Cache_VALID,
        input  GNT, ERR
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// Purpose: round-robin sharing of one cache port between fetch (I) and load/store (D).
// Latency: REQ seen in IDLE -> C_REQ next cycle -> DONE 3 cycles after REQ with no stalls.
// Backpressure: C_REQ held with stable fields until Cache_RDY; WAIT bounded by a TIMEOUT watchdog.
// Ports: CLK/RST plain; bus (master modport) carries I_*, D_*, C_*, Cache_RDY/VALID, GNT, ERR.
module cache_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    cache_port_arbiter_if.master  bus
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_last_d;     // 1 when D owned the previous transaction
    logic [1:0]    r_gnt;
    logic          r_c_req;
    logic          r_c_we;
    logic [3:0]    r_c_be;
    logic [AW-1:0] r_c_addr;
    logic [DW-1:0] r_c_wdata;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          r_i_done;
    logic          r_d_done;
    logic          r_err;

    // I wins unless D also requests and I was the last owner.
    logic w_pick_i;
    logic w_pick_d;
    logic w_own_i;
    assign w_pick_i = bus.I_REQ && (!bus.D_REQ || r_last_d);
    assign w_pick_d = bus.D_REQ && !w_pick_i;
    assign w_own_i  = (r_gnt == GNT_I);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_last_d  <= 1'b1;
            r_gnt     <= GNT_NONE;
            r_c_req   <= 1'b0;
            r_c_we    <= 1'b0;
            r_c_be    <= '0;
            r_c_addr  <= '0;
            r_c_wdata <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_done  <= 1'b0;
            r_d_done  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_i) begin
                        r_gnt     <= GNT_I;
                        r_c_req   <= 1'b1;
                        r_c_we    <= 1'b0;
                        r_c_be    <= 4'b1111;
                        r_c_addr  <= bus.I_ADDR;
                        r_c_wdata <= '0;
                        r_state   <= S_ISSUE;
                    end else if (w_pick_d) begin
                        r_gnt     <= GNT_D;
                        r_c_req   <= 1'b1;
                        r_c_we    <= bus.D_WE;
                        r_c_be    <= bus.D_BE;
                        r_c_addr  <= bus.D_ADDR;
                        r_c_wdata <= bus.D_WDATA;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.Cache_RDY) begin
                        r_c_req <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A completion on the last watchdog cycle still counts as success.
                    if (bus.Cache_VALID) begin
                        if (w_own_i) begin
                            r_i_rdata <= bus.C_RDATA;
                        end else if (!r_c_we) begin
                            r_d_rdata <= bus.C_RDATA;
                        end
                        r_i_done <= w_own_i;
                        r_d_done <= !w_own_i;
                        r_state  <= S_RESP;
                    end else if (r_cnt == CNT_MAX) begin
                        r_err    <= 1'b1;
                        r_i_done <= w_own_i;
                        r_d_done <= !w_own_i;
                        r_state  <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_i_done <= 1'b0;
                    r_d_done <= 1'b0;
                    r_last_d <= !w_own_i;
                    r_gnt    <= GNT_NONE;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.C_REQ   = r_c_req;
    assign bus.C_WE    = r_c_we;
    assign bus.C_BE    = r_c_be;
    assign bus.C_ADDR  = r_c_addr;
    assign bus.C_WDATA = r_c_wdata;
    assign bus.I_RDATA = r_i_rdata;
    assign bus.D_RDATA = r_d_rdata;
    assign bus.I_DONE  = r_i_done;
    assign bus.D_DONE  = r_d_done;
    assign bus.GNT     = r_gnt;
    assign bus.ERR     = r_err;
endmodule

// File: tb/tb_cache_port_arbiter.sv
module tb_cache_port_arbiter;
    localparam int TO = 64;

    logic CLK;
    logic RST;
    int   total;
    int   bad;

    cache_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    cache_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Transaction-level reference: who owns the port, which step it is in,
    // how many WAIT cycles have elapsed, and what each output should show.
    int          m_step;     // 0 idle, 1 presenting, 2 awaiting data, 3 reporting
    int          m_own;      // 1 = I, 2 = D
    int          m_last;
    int          m_waited;
    logic        e_creq, e_cwe, e_idone, e_ddone, e_err;
    logic [3:0]  e_cbe;
    logic [1:0]  e_gnt;
    logic [31:0] e_caddr, e_cwdata, e_irdata, e_drdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        int  want;
        bit  fin;
        want = 0;
        fin  = 0;
        if (RST) begin
            m_step = 0; m_last = 2; m_waited = 0; m_own = 0;
            e_creq = 0; e_cwe = 0; e_cbe = 0; e_caddr = 0; e_cwdata = 0;
            e_irdata = 0; e_drdata = 0; e_idone = 0; e_ddone = 0; e_gnt = 0; e_err = 0;
            return;
        end
        case (m_step)
            0: begin
                if (bus.I_REQ && bus.D_REQ) want = (m_last == 1) ? 2 : 1;
                else if (bus.I_REQ)         want = 1;
                else if (bus.D_REQ)         want = 2;
                if (want == 1) begin
                    e_cwe = 0; e_cbe = 4'hF; e_caddr = bus.I_ADDR; e_cwdata = 0;
                end else if (want == 2) begin
                    e_cwe = bus.D_WE; e_cbe = bus.D_BE; e_caddr = bus.D_ADDR; e_cwdata = bus.D_WDATA;
                end
                if (want != 0) begin
                    m_own = want; e_gnt = 2'(want); e_creq = 1; m_step = 1;
                end
            end
            1: if (bus.Cache_RDY) begin
                e_creq = 0; m_waited = 0; m_step = 2;
            end
            2: begin
                m_waited++;
                if (bus.Cache_VALID) begin
                    if (m_own == 1)   e_irdata = bus.C_RDATA;
                    else if (!e_cwe)  e_drdata = bus.C_RDATA;
                    fin = 1;
                end else if (m_waited == TO) begin
                    e_err = 1; fin = 1;
                end
                if (fin) begin
                    e_idone = (m_own == 1); e_ddone = (m_own == 2); m_step = 3;
                end
            end
            default: begin
                e_idone = 0; e_ddone = 0; e_gnt = 0; m_last = m_own; m_step = 0;
            end
        endcase
    endtask

    task automatic compare_all();
        chk("C_REQ",   32'(bus.C_REQ),   32'(e_creq));
        chk("C_WE",    32'(bus.C_WE),    32'(e_cwe));
        chk("C_BE",    32'(bus.C_BE),    32'(e_cbe));
        chk("C_ADDR",  bus.C_ADDR,       e_caddr);
        chk("C_WDATA", bus.C_WDATA,      e_cwdata);
        chk("I_RDATA", bus.I_RDATA,      e_irdata);
        chk("D_RDATA", bus.D_RDATA,      e_drdata);
        chk("I_DONE",  32'(bus.I_DONE),  32'(e_idone));
        chk("D_DONE",  32'(bus.D_DONE),  32'(e_ddone));
        chk("GNT",     32'(bus.GNT),     32'(e_gnt));
        chk("ERR",     32'(bus.ERR),     32'(e_err));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic quiet();
        bus.I_REQ = 0; bus.I_ADDR = 0;
        bus.D_REQ = 0; bus.D_WE = 0; bus.D_BE = 0; bus.D_ADDR = 0; bus.D_WDATA = 0;
        bus.C_RDATA = 0; bus.Cache_RDY = 0; bus.Cache_VALID = 0;
    endtask

    task automatic do_reset();
        RST = 1; tick(); tick(); RST = 0;
    endtask

    initial begin
        int n;
        int seq[4];
        int ns;
        total = 0; bad = 0;
        m_step = 0; m_own = 0; m_last = 2; m_waited = 0;
        e_creq = 0; e_cwe = 0; e_cbe = 0; e_caddr = 0; e_cwdata = 0;
        e_irdata = 0; e_drdata = 0; e_idone = 0; e_ddone = 0; e_gnt = 0; e_err = 0;
        RST = 1;
        quiet();
        do_reset();
        chk("rst_gnt", 32'(bus.GNT), 32'd0);
        chk("rst_creq", 32'(bus.C_REQ), 32'd0);
        chk("rst_err", 32'(bus.ERR), 32'd0);

        // Single fetch.
        bus.I_REQ = 1; bus.I_ADDR = 32'h100; bus.Cache_RDY = 1;
        tick();
        chk("fetch_creq_c1", 32'(bus.C_REQ), 32'd1);
        chk("fetch_addr", bus.C_ADDR, 32'h100);
        chk("fetch_be", 32'(bus.C_BE), 32'hF);
        tick();
        chk("fetch_gnt_wait", 32'(bus.GNT), 32'd1);
        bus.Cache_VALID = 1; bus.C_RDATA = 32'h00500093;
        tick();
        chk("fetch_done_c3", 32'(bus.I_DONE), 32'd1);
        chk("fetch_rdata", bus.I_RDATA, 32'h00500093);
        bus.I_REQ = 0; bus.Cache_VALID = 0;
        tick();
        chk("fetch_done_drop", 32'(bus.I_DONE), 32'd0);
        chk("fetch_gnt_clr", 32'(bus.GNT), 32'd0);

        // Store with three stall cycles.
        bus.D_REQ = 1; bus.D_WE = 1; bus.D_BE = 4'hF; bus.D_ADDR = 32'h2000;
        bus.D_WDATA = 32'hDEADBEEF; bus.Cache_RDY = 0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("store_creq_held", 32'(bus.C_REQ), 32'd1);
            chk("store_wdata_held", bus.C_WDATA, 32'hDEADBEEF);
            chk("store_addr_held", bus.C_ADDR, 32'h2000);
            if (k == 3) bus.Cache_RDY = 1;
            tick();
        end
        chk("store_creq_drop", 32'(bus.C_REQ), 32'd0);
        bus.Cache_VALID = 1; bus.C_RDATA = 32'h55AA55AA;
        tick();
        chk("store_done", 32'(bus.D_DONE), 32'd1);
        chk("store_rdata_kept", bus.D_RDATA, 32'd0);
        bus.D_REQ = 0; bus.Cache_VALID = 0;
        tick();
        chk("store_done_once", 32'(bus.D_DONE), 32'd0);

        // Both held after reset: grants alternate starting with I.
        do_reset();
        bus.I_REQ = 1; bus.I_ADDR = 32'h40; bus.D_REQ = 1; bus.D_WE = 0;
        bus.D_ADDR = 32'h3000; bus.Cache_RDY = 1; bus.Cache_VALID = 1; bus.C_RDATA = 32'h1234;
        ns = 0;
        for (int k = 0; k < 40 && ns < 4; k++) begin
            tick();
            if (bus.I_DONE) begin seq[ns] = 1; ns++; end
            else if (bus.D_DONE) begin seq[ns] = 2; ns++; end
        end
        chk("alt_count", 32'(ns), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < ns) chk("alt_order", 32'(seq[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        quiet();
        tick(); tick();

        // Watchdog expiry on a D load.
        do_reset();
        bus.D_REQ = 1; bus.D_WE = 0; bus.D_BE = 4'h3; bus.D_ADDR = 32'h44; bus.Cache_RDY = 1;
        tick(); tick();
        n = 0;
        while (!bus.D_DONE && n < 200) begin tick(); n++; end
        chk("to_wait_cycles", 32'(n), 32'd64);
        chk("to_err", 32'(bus.ERR), 32'd1);
        chk("to_rdata_kept", bus.D_RDATA, 32'd0);
        bus.D_REQ = 0;
        tick();
        bus.I_REQ = 1; bus.I_ADDR = 32'h80;
        tick(); tick();
        bus.Cache_VALID = 1; bus.C_RDATA = 32'hCAFE0001;
        tick();
        chk("after_to_done", 32'(bus.I_DONE), 32'd1);
        chk("after_to_rdata", bus.I_RDATA, 32'hCAFE0001);
        chk("err_sticky", 32'(bus.ERR), 32'd1);
        quiet();
        tick();

        // Completion on the final watchdog cycle.
        do_reset();
        bus.D_REQ = 1; bus.D_WE = 0; bus.D_BE = 4'hF; bus.D_ADDR = 32'h48; bus.Cache_RDY = 1;
        tick(); tick();
        for (int k = 0; k < TO - 1; k++) tick();
        bus.Cache_VALID = 1; bus.C_RDATA = 32'h12345678;
        tick();
        chk("col_done", 32'(bus.D_DONE), 32'd1);
        chk("col_rdata", bus.D_RDATA, 32'h12345678);
        chk("col_err", 32'(bus.ERR), 32'd0);
        quiet();
        tick();

        // Reset during WAIT, then a stray completion.
        bus.D_REQ = 1; bus.D_ADDR = 32'h4C; bus.Cache_RDY = 1;
        tick(); tick();
        RST = 1; bus.D_REQ = 0;
        tick();
        RST = 0; bus.Cache_VALID = 1; bus.C_RDATA = 32'hBADBAD00;
        chk("rstw_gnt", 32'(bus.GNT), 32'd0);
        chk("rstw_addr", bus.C_ADDR, 32'd0);
        chk("rstw_rdata", bus.D_RDATA, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rstw_no_done", 32'(bus.D_DONE), 32'd0);
        end
        chk("rstw_stray_ignored", bus.D_RDATA, 32'd0);
        quiet();

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            RST = ($urandom_range(0, 599) == 0);
            if (bus.I_DONE) bus.I_REQ = 0;
            else if (!bus.I_REQ && $urandom_range(0, 9) < 4) begin
                bus.I_REQ = 1; bus.I_ADDR = $urandom;
            end
            if (bus.D_DONE) bus.D_REQ = 0;
            else if (!bus.D_REQ && $urandom_range(0, 9) < 4) begin
                bus.D_REQ = 1; bus.D_WE = 1'($urandom); bus.D_BE = 4'($urandom);
                bus.D_ADDR = $urandom; bus.D_WDATA = $urandom;
            end
            bus.Cache_RDY   = ($urandom_range(0, 9) < 7);
            bus.Cache_VALID = ($urandom_range(0, 9) < 5);
            bus.C_RDATA     = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
Arbitrates a single cache port between the instruction-fetch requester (I, read-only) and the load/store requester (D, read/write) of the multicycle RISC-V core. Each transaction is latched and presented to the cache with a request/ready handshake. The block then waits for the cache's completion strobe and returns read data with a one-cycle done pulse to the owning requester. Round-robin arbitration and a response watchdog prevent starvation and hangs.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 64, max cycles in WAIT before error completion (>=2)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
I_REQ  in  1  fetch request, level, held until I_DONE
I_ADDR  in  AW  fetch address
I_RDATA  out  DW  registered fetch data
I_DONE  out  1  one-cycle completion pulse to I
D_REQ  in  1  data request, level, held until D_DONE
D_WE  in  1  1=store, 0=load
D_BE  in  4  byte enables
D_ADDR  in  AW  data address
D_WDATA  in  DW  store data
D_RDATA  out  DW  registered load data
D_DONE  out  1  one-cycle completion pulse to D
C_REQ  out  1  request valid to cache
C_WE  out  1  write enable to cache
C_BE  out  4  byte enables to cache
C_ADDR  out  AW  address to cache
C_WDATA  out  DW  write data to cache
C_RDATA  in  DW  cache read data, valid with Cache_VALID
Cache_RDY  in  1  cache accepts request this cycle
Cache_VALID  in  1  cache completed current access
GNT  out  2  current owner: 00 none, 01 I, 10 D
ERR  out  1  sticky timeout flag

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset values: FSM=IDLE, C_REQ=0, C_WE=0, C_BE=0, C_ADDR=0, C_WDATA=0, I_RDATA=0, D_RDATA=0, I_DONE=0, D_DONE=0, GNT=00, ERR=0, LAST=D, so I wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE transitions:
  - Only one requester active: grant it.
  - Both active: grant the one not equal to LAST.
  - On grant, latch the owner's ADDR/WE/BE/WDATA (I forces WE=0, BE=1111) into the C_* registers, set GNT, and go to ISSUE.
  - No request: stay in IDLE.
- ISSUE: C_REQ=1 with latched fields stable. If Cache_RDY=1 at the edge, go to WAIT and clear the watchdog count; otherwise stay and hold all fields.
- WAIT: C_REQ=0; the watchdog counts up each cycle.
  - Cache_VALID=1: if the owner is I, or D with WE=0, capture C_RDATA into the owner's RDATA register; go to RESP.
  - Count reaches TIMEOUT-1 without Cache_VALID: set ERR, leave RDATA unchanged, go to RESP.
  - Cache_VALID and timeout in the same cycle: Cache_VALID wins, ERR is not set.
- RESP: the owner's DONE=1 for exactly one cycle; LAST=owner; GNT=00; go to IDLE.
- Requester protocol: the requester holds REQ and its fields stable until its DONE and deasserts REQ no later than the cycle after DONE. REQ seen in IDLE is always treated as a new request.
- Minimum latency: REQ at cycle 0 → C_REQ cycle 1 (RDY=1) → WAIT cycle 2 (VALID=1) → DONE cycle 3. Each Cache_RDY stall or missing VALID adds one cycle.
- Ignored cache inputs:
  - Cache_VALID in IDLE, ISSUE, or RESP is ignored; there is no buffering.
  - Cache_RDY outside ISSUE is ignored.
- Stores never modify D_RDATA. RDATA registers hold their value until the next read completion for that port.
- RST asserted in any state returns to IDLE next cycle with all reset values, including clearing ERR. An in-flight cache response arriving after reset is ignored.
- The losing requester keeps its REQ asserted and wins the next arbitration, so it waits at most one transaction.

Test Plan:
- Single fetch: I_REQ=1, I_ADDR=0x100, RDY=1, VALID in first WAIT cycle with C_RDATA=0x00500093 → C_REQ cycle 1, I_DONE pulse cycle 3, I_RDATA=0x00500093, GNT 01→00.
- Store with stall: D_WE=1, D_BE=1111, D_ADDR=0x2000, D_WDATA=0xDEADBEEF, Cache_RDY low 3 cycles → C_REQ held 4 cycles with stable fields, D_DONE once, D_RDATA unchanged.
- Simultaneous I_REQ and D_REQ after reset → I served first, D second; repeat with both held → grants alternate I, D, I, D.
- Timeout: D load, Cache_VALID never asserted, TIMEOUT=64 → D_DONE after 64 WAIT cycles, ERR=1 sticky, D_RDATA unchanged; next transaction completes normally with ERR still 1.
- Timeout collision: Cache_VALID asserted exactly on the TIMEOUT-1 cycle → data captured, ERR stays 0.
- Reset mid-WAIT: RST one cycle during WAIT, then stray Cache_VALID → IDLE, no DONE, all outputs zero, stray VALID ignored.
